// File: rtl/ahb_lite_interconnect_n_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_interconnect_n_if
// Bundles the master-side and slave-side AHB-Lite signals that pass through
// the single-master interconnect.
//
// Master side : HADDR, HTRANS (from master); HREADY, HRESP, HRDATA (to master)
// Slave side  : HSEL_S, HREADY_S (to slaves); HREADYOUT_S, HRESP_S, HRDATA_S
//               (from slaves, slave i at [i*DATA_WIDTH +: DATA_WIDTH])
//
// Modports:
//   master - the bus master's view (drives address phase, receives response)
//   slave  - the view of the block sitting on the master's bus, i.e. the
//            interconnect: it receives the address phase and drives the
//            response plus the slave-side selects.
// ---------------------------------------------------------------------------
interface ahb_lite_interconnect_n_if #(
   parameter int NUM_SLAVES = 5,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]            HADDR;
   logic [1:0]                       HTRANS;
   logic                             HREADY;
   logic                             HRESP;
   logic [DATA_WIDTH-1:0]            HRDATA;
   logic [NUM_SLAVES-1:0]            HSEL_S;
   logic                             HREADY_S;
   logic [NUM_SLAVES-1:0]            HREADYOUT_S;
   logic [NUM_SLAVES-1:0]            HRESP_S;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S;

   modport master (
      output HADDR, HTRANS,
      input  HREADY, HRESP, HRDATA
   );

   modport slave (
      input  HADDR, HTRANS,
      output HREADY, HRESP, HRDATA,
      output HSEL_S, HREADY_S,
      input  HREADYOUT_S, HRESP_S, HRDATA_S
   );
endinterface

// File: rtl/ahb_lite_interconnect_n.sv
// ---------------------------------------------------------------------------
// ahb_lite_interconnect_n
// Single-master AHB-Lite interconnect: decodes the address phase onto
// NUM_SLAVES one-hot selects through a programmable base/mask map and
// multiplexes the data-phase response of the addressed slave back to the
// master. Active transfers to unmapped addresses are answered by an internal
// default slave with a two-cycle ERROR response.
//
// Ports:
//   HCLK         in   bus clock
//   HRESET       in   synchronous active-high reset
//   TIMEOUT_FLAG out  sticky hung-slave indicator (AHB_IC_TIMEOUT_EN only)
//   bus          slave modport of ahb_lite_interconnect_n_if (address phase
//                in, response out, slave selects/responses)
//
// Optional feature macro: AHB_IC_TIMEOUT_EN
//   When defined, a wait-state counter turns a slave stalled for
//   TIMEOUT_CYCLES cycles into a two-cycle ERROR and sets TIMEOUT_FLAG.
//   When undefined, slave wait states may last indefinitely and there is no
//   TIMEOUT_CYCLES parameter or TIMEOUT_FLAG port.
// ---------------------------------------------------------------------------
module ahb_lite_interconnect_n #(
   parameter int NUM_SLAVES = 5,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = {
      32'h4002_0000, 32'h4001_0000, 32'h0000_0000, 32'h2000_0000, 32'h4000_0000},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {
      32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000}
`ifdef AHB_IC_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 256
`endif
) (
   input  logic HCLK,
   input  logic HRESET,
`ifdef AHB_IC_TIMEOUT_EN
   output logic TIMEOUT_FLAG,
`endif
   ahb_lite_interconnect_n_if.slave bus
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   // Data-phase owner: nobody, a real slave (index in dsel_idx), or the
   // internal default slave.
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_SLV  = 2'd1,
      SEL_DEF  = 2'd2
   } dsel_kind_e;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } def_state_e;

   dsel_kind_e        dsel_kind_q, dsel_kind_d;
   logic [IDX_W-1:0]  dsel_idx_q,  dsel_idx_d;
   def_state_e        def_st_q,    def_st_d;

   logic                  hit;
   logic [IDX_W-1:0]      hit_idx;
   logic [NUM_SLAVES-1:0] hsel;
   logic                  hready;
   logic                  hresp;
   logic [DATA_WIDTH-1:0] hrdata;

   // Only NONSEQ/SEQ vs IDLE/BUSY matters to the interconnect.
   logic unused_htrans0;
   assign unused_htrans0 = bus.HTRANS[0];

`ifdef AHB_IC_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          to_flag_q,  to_flag_d;
`endif

   // Address decode. Scanning from the top index down lets the lowest
   // matching index overwrite higher ones, so overlaps resolve to the lowest.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((bus.HADDR & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
             SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
      hsel = hit ? (NUM_SLAVES'(1) << hit_idx) : '0;
   end

   // Data-phase response mux.
   always_comb begin
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = '0;
      case (dsel_kind_q)
         SEL_SLV: begin
            hready = bus.HREADYOUT_S[dsel_idx_q];
            hresp  = bus.HRESP_S[dsel_idx_q];
            hrdata = bus.HRDATA_S[int'(dsel_idx_q)*DATA_WIDTH +: DATA_WIDTH];
         end
         SEL_DEF: begin
            hready = (def_st_q != DS_ERR1);
            hresp  = (def_st_q != DS_IDLE);
         end
         default: ;
      endcase
   end

   // Next-state: data-phase select and default-slave FSM.
   always_comb begin
      dsel_kind_d = dsel_kind_q;
      dsel_idx_d  = dsel_idx_q;
      def_st_d    = def_st_q;
`ifdef AHB_IC_TIMEOUT_EN
      wait_cnt_d  = wait_cnt_q;
      to_flag_d   = to_flag_q;
`endif

      case (def_st_q)
         DS_ERR1: def_st_d = DS_ERR2;
         default: def_st_d = DS_IDLE;
      endcase

      if (hready) begin
         if (hit) begin
            dsel_kind_d = SEL_SLV;
            dsel_idx_d  = hit_idx;
         end else if (bus.HTRANS[1]) begin
            // Active transfer to a hole: the default slave answers, and a
            // reload from ERR2 restarts the pair with no gap.
            dsel_kind_d = SEL_DEF;
            def_st_d    = DS_ERR1;
         end else begin
            dsel_kind_d = SEL_NONE;
         end
      end

`ifdef AHB_IC_TIMEOUT_EN
      if (hready || (dsel_kind_q != SEL_SLV)) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q == CNT_LAST) begin
         // Hung slave: hand the data phase to the default slave so the
         // master sees ERR1/ERR2; the counter holds (saturates) until the
         // select change clears it.
         dsel_kind_d = SEL_DEF;
         def_st_d    = DS_ERR1;
         to_flag_d   = 1'b1;
      end else begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
`endif
   end

   // Register stage: address phase -> data phase.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dsel_kind_q <= SEL_NONE;
         dsel_idx_q  <= '0;
         def_st_q    <= DS_IDLE;
`ifdef AHB_IC_TIMEOUT_EN
         wait_cnt_q  <= '0;
         to_flag_q   <= 1'b0;
`endif
      end else begin
         dsel_kind_q <= dsel_kind_d;
         dsel_idx_q  <= dsel_idx_d;
         def_st_q    <= def_st_d;
`ifdef AHB_IC_TIMEOUT_EN
         wait_cnt_q  <= wait_cnt_d;
         to_flag_q   <= to_flag_d;
`endif
      end
   end

   assign bus.HSEL_S   = hsel;
   assign bus.HREADY   = hready;
   assign bus.HREADY_S = hready;
   assign bus.HRESP    = hresp;
   assign bus.HRDATA   = hrdata;
`ifdef AHB_IC_TIMEOUT_EN
   assign TIMEOUT_FLAG = to_flag_q;
`endif

endmodule

// File: doc/ahb_lite_interconnect_n.md
# ahb_lite_interconnect_n

Parametrised single-master AHB-Lite interconnect that decodes the master address phase onto NUM_SLAVES slave selects and multiplexes the addressed slave's data-phase response back to the master. It replaces the fixed five-slave interconnect in the SoC bus fabric. It adds a programmable address map, an internal default slave that returns two-cycle ERROR for unmapped transfers, and an optional hung-slave timeout.

## Interface
- NUM_SLAVES, 5, number of slave ports (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, read data width
- SLV_BASE, {0x4000_0000,0x2000_0000,0x0000_0000,0x4001_0000,0x4002_0000}, packed NUM_SLAVES×ADDR_WIDTH base addresses, slave i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- SLV_MASK, per-slave region masks, packed like SLV_BASE
- TIMEOUT_CYCLES, 256, wait-state limit (only with AHB_IC_TIMEOUT_EN)

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  reset, synchronous, active-high
- HADDR  in  ADDR_WIDTH  master address
- HTRANS  in  2  master transfer type
- HREADY  out  1  ready to master and to all slaves
- HRESP  out  1  response to master
- HRDATA  out  DATA_WIDTH  read data to master
- HSEL_S  out  NUM_SLAVES  one-hot slave selects
- HREADY_S  out  1  copy of HREADY for slaves
- HREADYOUT_S  in  NUM_SLAVES  slave ready outputs
- HRESP_S  in  NUM_SLAVES  slave responses
- HRDATA_S  in  NUM_SLAVES×DATA_WIDTH  slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- TIMEOUT_FLAG  out  1  sticky timeout indicator (only with AHB_IC_TIMEOUT_EN)

Broadcast master signals (HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA) are wired directly at the top level.

## Operation
- Decode is combinational. Slave i matches when (HADDR & SLV_MASK[i]) == SLV_BASE[i].
  - On overlapping regions the lowest index wins.
  - HSEL_S is at most one-hot and does not depend on HTRANS.
- Data-phase select register dsel holds one of: NONE, slave index, or DEF (default slave). It updates only on HCLK edges with HREADY=1:
  - a matched slave index, if any slave matches;
  - else DEF, if HTRANS[1]=1 (NONSEQ or SEQ);
  - else NONE.
- Output mux:
  - dsel=i: HREADY, HRESP and HRDATA come from slave i.
  - dsel=NONE: HREADY=1, HRESP=0, HRDATA=0.
  - dsel=DEF: default-slave FSM drives HREADY and HRESP; HRDATA=0.
- Default-slave FSM:
  - IDLE→ERR1 when dsel loads DEF.
  - ERR1 outputs HREADY=0, HRESP=1; next state ERR2.
  - ERR2 outputs HREADY=1, HRESP=1; next state IDLE, or ERR1 if dsel reloads DEF.
- IDLE or BUSY transfers to unmapped addresses complete with zero wait states and OKAY.
- Reset values: dsel=NONE, FSM=IDLE, HREADY=1, HRESP=0, HRDATA=0, TIMEOUT_FLAG=0. HSEL_S follows HADDR combinationally.
- Reset asserted mid-transfer abandons the data phase. Outputs take reset values on the next edge.

## Timing
- Combinational paths:
  - HADDR→HSEL_S.
  - HREADYOUT_S, HRESP_S, HRDATA_S→HREADY, HRESP, HRDATA.
- One register stage (dsel): the address phase at edge N selects the data-phase source from cycle N+1.
- Unmapped active transfer: exactly 2 data-phase cycles (ERR1, ERR2).
- Back-to-back unmapped transfers produce repeated ERR1/ERR2 pairs with no gap cycle.
- Pipelined address phase during ERR2 is accepted at the ERR2 edge.
- Slave wait states (HREADYOUT_S[i]=0) hold dsel and pass through unchanged.

## Configuration
- AHB_IC_TIMEOUT_EN defined: a wait counter is added.
  - It clears whenever HREADY=1 or dsel is not a slave index.
  - It increments on each cycle with dsel=i and HREADYOUT_S[i]=0.
  - At TIMEOUT_CYCLES−1 the interconnect overrides slave i with a two-cycle ERROR (same ERR1/ERR2 sequence, slave outputs ignored).
  - TIMEOUT_FLAG sets and stays set until reset.
  - The counter is ceil(log2(TIMEOUT_CYCLES)) bits and saturates.
- AHB_IC_TIMEOUT_EN undefined: no counter and no TIMEOUT_FLAG port. Slave wait states can last indefinitely.

## Test plan
- Reset: HRESET=1 for 2 cycles → HREADY=1, HRESP=0, HRDATA=0, dsel=NONE.
- Decode: NONSEQ read to 0x2000_0010 with slave 1 returning 0xA5A5_5A5A after 2 wait states → HSEL_S=5'b00010 in the address phase; HREADY low for 2 cycles; then HRDATA=0xA5A5_5A5A with HRESP=0.
- Unmapped: NONSEQ to 0x8000_0000 → HSEL_S=0; next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1. IDLE to the same address → OKAY with zero waits.
- Back-to-back: NONSEQ to slave 0, slave 2, then an unmapped address, each pipelined → responses sourced from the correct slave per data phase, with no extra cycles beyond slave waits plus ERR1/ERR2.
- Overlap/parameters: NUM_SLAVES=2 with overlapping regions → slave 0 selected.
- Reset mid-transfer: HRESET asserted during a slave 3 wait state → dsel=NONE next cycle.
- Timeout (AHB_IC_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave holds HREADYOUT_S low → ERROR pair starts after 8 wait cycles; TIMEOUT_FLAG=1 until reset.
